// File: rtl/product_selector_multi.sv
// Product selector: a selection must stay stable for HOLD_CYCLES before it commits a code and price.
// Optional per-product stock tracking is enabled by defining PRODUCT_STOCK_EN.
module product_selector_multi #(
    parameter int unsigned        NUM_PRODUCTS  = 3,
    parameter int unsigned        SEL_W         = 2,
    parameter int unsigned        PRICE_W       = 5,
    parameter logic [PRICE_W-1:0] DEFAULT_PRICE = 5'd15,
    parameter int unsigned        HOLD_CYCLES   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sel_valid,
    input  logic [SEL_W-1:0]   product_sel,
    input  logic               cancel,
    input  logic               done_ack,
    input  logic               cfg_we,
    input  logic [SEL_W-1:0]   cfg_addr,
    input  logic [PRICE_W-1:0] cfg_price,
    output logic [SEL_W-1:0]   product_out,
    output logic [PRICE_W-1:0] product_price,
    output logic               product_selector_done,
    output logic               busy,
    output logic               sel_err
`ifdef PRODUCT_STOCK_EN
    ,
    input  logic               stock_we,
    input  logic [7:0]         stock_cnt_in
`endif
);

    localparam int unsigned      CNT_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [SEL_W-1:0] MAX_CODE = SEL_W'(NUM_PRODUCTS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

    state_t             state;
    logic [SEL_W-1:0]   pending;
    logic [CNT_W-1:0]   cnt;
    logic [PRICE_W-1:0] price_tbl [NUM_PRODUCTS+1];

    logic code_ok;
    logic sel_ok;
    logic cfg_ok;
    logic restart;
    logic commit;

`ifdef PRODUCT_STOCK_EN
    localparam int unsigned       STOCK_W     = 8;
    localparam logic [STOCK_W-1:0] STOCK_RESET = 8'd10;

    logic [STOCK_W-1:0] stock [NUM_PRODUCTS+1];
`endif

    // Selection/config address decode and the commit condition
    always_comb begin
        code_ok = (product_sel != '0) && (product_sel <= MAX_CODE);
`ifdef PRODUCT_STOCK_EN
        sel_ok  = code_ok && (stock[product_sel] != '0);
`else
        sel_ok  = code_ok;
`endif
        cfg_ok  = (cfg_addr != '0) && (cfg_addr <= MAX_CODE);
        restart = sel_valid && sel_ok;
        commit  = (state == HOLD) && !cancel && !restart && (cnt == LAST_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= IDLE;
            pending               <= '0;
            cnt                   <= '0;
            product_out           <= '0;
            product_price         <= '0;
            product_selector_done <= 1'b0;
            busy                  <= 1'b0;
            sel_err               <= 1'b0;
            price_tbl             <= '{default: DEFAULT_PRICE};
        end else begin
            sel_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        if (sel_ok) begin
                            pending <= product_sel;
                            cnt     <= '0;
                            state   <= HOLD;
                            busy    <= 1'b1;
                        end else begin
                            sel_err <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else if (restart) begin
                        pending <= product_sel;
                        cnt     <= '0;
                    end else begin
                        sel_err <= sel_valid;
                        if (commit) begin
                            // Non-blocking read returns the pre-write price on a same-cycle cfg_we
                            product_out           <= pending;
                            product_price         <= price_tbl[pending];
                            product_selector_done <= 1'b1;
                            state                 <= DONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (done_ack) begin
                        product_selector_done <= 1'b0;
                        state                 <= IDLE;
                        busy                  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (cfg_we && cfg_ok) begin
                price_tbl[cfg_addr] <= cfg_price;
            end
        end
    end

`ifdef PRODUCT_STOCK_EN
    // Stock bookkeeping: an explicit load of the same entry overrides the commit decrement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stock <= '{default: STOCK_RESET};
        end else begin
            if (commit && (stock[pending] != '0)) begin
                stock[pending] <= stock[pending] - STOCK_W'(1);
            end
            if (stock_we && cfg_ok) begin
                stock[cfg_addr] <= stock_cnt_in;
            end
        end
    end
`endif

endmodule

// File: tb/tb_product_selector_multi.sv
// Randomized and directed bench for product_selector_multi against a timestamp-based reference model.
module tb_product_selector_multi;

    localparam int NP    = 3;
    localparam int SEL_W = 2;
    localparam int PW    = 5;
    localparam int HOLD  = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          sel_valid = 1'b0;
    logic [SEL_W-1:0] product_sel = '0;
    logic          cancel = 1'b0;
    logic          done_ack = 1'b0;
    logic          cfg_we = 1'b0;
    logic [SEL_W-1:0] cfg_addr = '0;
    logic [PW-1:0] cfg_price = '0;
    logic [SEL_W-1:0] product_out;
    logic [PW-1:0] product_price;
    logic          product_selector_done;
    logic          busy;
    logic          sel_err;
`ifdef PRODUCT_STOCK_EN
    logic          stock_we = 1'b0;
    logic [7:0]    stock_cnt_in = '0;
`endif

    product_selector_multi dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .sel_valid            (sel_valid),
        .product_sel          (product_sel),
        .cancel               (cancel),
        .done_ack             (done_ack),
        .cfg_we               (cfg_we),
        .cfg_addr             (cfg_addr),
        .cfg_price            (cfg_price),
        .product_out          (product_out),
        .product_price        (product_price),
        .product_selector_done(product_selector_done),
        .busy                 (busy),
        .sel_err              (sel_err)
`ifdef PRODUCT_STOCK_EN
        ,
        .stock_we             (stock_we),
        .stock_cnt_in         (stock_cnt_in)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: mode 0=idle 1=hold 2=done; commit is due HOLD edges after the last accepted strobe
    int m_mode, m_pend, m_due, m_out, m_price, m_done, m_err, cyc;
    int m_tbl [0:NP];
    int m_stock [0:NP];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pend = 0; m_due = 0; m_out = 0; m_price = 0; m_done = 0; m_err = 0;
        for (int i = 0; i <= NP; i++) begin
            m_tbl[i]   = 15;
            m_stock[i] = 10;
        end
    endtask

    task automatic check_all();
        chk("done",  32'(product_selector_done), 32'(m_done));
        chk("out",   32'(product_out),           32'(m_out));
        chk("price", 32'(product_price),         32'(m_price));
        chk("busy",  32'(busy),                  32'(m_mode != 0));
        chk("err",   32'(sel_err),               32'(m_err));
    endtask

    task automatic step(input bit sv, input int ps, input bit cn, input bit ack,
                        input bit cwe, input int ca, input int cp,
                        input bit swe = 1'b0, input int sc = 0);
        bit ok;
        sel_valid = sv; product_sel = SEL_W'(ps); cancel = cn; done_ack = ack;
        cfg_we = cwe; cfg_addr = SEL_W'(ca); cfg_price = PW'(cp);
`ifdef PRODUCT_STOCK_EN
        stock_we = swe; stock_cnt_in = 8'(sc);
        ok = (ps >= 1) && (ps <= NP) && (m_stock[ps] != 0);
`else
        ok = (ps >= 1) && (ps <= NP);
`endif
        cyc++;
        m_err = 0;
        case (m_mode)
            0: if (sv) begin
                   if (ok) begin m_mode = 1; m_pend = ps; m_due = cyc + HOLD; end
                   else m_err = 1;
               end
            1: if (cn) m_mode = 0;
               else if (sv && ok) begin m_pend = ps; m_due = cyc + HOLD; end
               else begin
                   if (sv) m_err = 1;
                   if (cyc == m_due) begin
                       m_out = m_pend; m_price = m_tbl[m_pend]; m_done = 1; m_mode = 2;
`ifdef PRODUCT_STOCK_EN
                       if (m_stock[m_pend] > 0) m_stock[m_pend]--;
`endif
                   end
               end
            default: if (ack) begin m_done = 0; m_mode = 0; end
        endcase
        if (cwe && ca >= 1 && ca <= NP) m_tbl[ca] = cp;
`ifdef PRODUCT_STOCK_EN
        if (swe && ca >= 1 && ca <= NP) m_stock[ca] = sc;
`endif
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_done",  32'(product_selector_done), 32'd0);
        chk("rst_out",   32'(product_out),           32'd0);
        chk("rst_price", 32'(product_price),         32'd0);
        chk("rst_busy",  32'(busy),                  32'd0);
        chk("rst_err",   32'(sel_err),               32'd0);
        model_reset();
        sel_valid = 0; cancel = 0; done_ack = 0; cfg_we = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        cyc = 0;
        model_reset();
        @(negedge clk);
        async_reset();

        // Basic commit: done exactly HOLD edges after the strobe
        step(1, 2, 0, 0, 0, 0, 0);
        idle(HOLD - 1);
        chk("basic_early", 32'(product_selector_done), 32'd0);
        idle(1);
        chk("basic_done",  32'(product_selector_done), 32'd1);
        chk("basic_out",   32'(product_out),           32'd2);
        chk("basic_price", 32'(product_price),         32'd15);
        idle(2);
        chk("basic_hold",  32'(product_selector_done), 32'd1);
        step(0, 0, 0, 1, 0, 0, 0);
        chk("basic_ack",   32'(product_selector_done), 32'd0);
        chk("basic_busy",  32'(busy),                  32'd0);

        // Price write then commit, and a write coinciding with commit
        step(0, 0, 0, 0, 1, 3, 25);
        step(1, 3, 0, 0, 0, 0, 0);
        idle(HOLD);
        chk("cfg_price", 32'(product_price), 32'd25);
        step(0, 0, 0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        idle(HOLD - 1);
        step(0, 0, 0, 0, 1, 1, 7);
        chk("same_cycle_old", 32'(product_price), 32'd15);
        step(0, 0, 0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        idle(HOLD);
        chk("new_price", 32'(product_price), 32'd7);
        step(0, 0, 0, 1, 0, 0, 0);

        // Restart three cycles into the window
        step(1, 1, 0, 0, 0, 0, 0);
        idle(2);
        step(1, 2, 0, 0, 0, 0, 0);
        idle(HOLD - 1);
        chk("restart_early", 32'(product_selector_done), 32'd0);
        idle(1);
        chk("restart_done", 32'(product_selector_done), 32'd1);
        chk("restart_out",  32'(product_out),           32'd2);
        step(0, 0, 0, 1, 0, 0, 0);

        // Cancel beats a simultaneous strobe; invalid code in idle
        step(1, 3, 0, 0, 0, 0, 0);
        idle(2);
        step(1, 1, 1, 0, 0, 0, 0);
        idle(HOLD + 1);
        chk("cancel_done", 32'(product_selector_done), 32'd0);
        chk("cancel_out",  32'(product_out),           32'd2);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("inv_err",  32'(sel_err), 32'd1);
        chk("inv_busy", 32'(busy),    32'd0);
        idle(1);
        chk("inv_pulse", 32'(sel_err), 32'd0);

        // Invalid code during hold does not restart the window
        step(1, 2, 0, 0, 0, 0, 0);
        idle(1);
        step(1, 0, 0, 0, 0, 0, 0);
        idle(HOLD - 2);
        chk("hold_inv_done", 32'(product_selector_done), 32'd1);
        step(0, 0, 0, 1, 0, 0, 0);

        // Reset mid-hold discards the selection
        step(1, 3, 0, 0, 0, 0, 0);
        idle(2);
        async_reset();
        idle(HOLD + 3);
        chk("post_rst_done", 32'(product_selector_done), 32'd0);

`ifdef PRODUCT_STOCK_EN
        step(0, 0, 0, 0, 0, 1, 0, 1, 1);
        step(1, 1, 0, 0, 0, 0, 0);
        idle(HOLD);
        chk("stock_first", 32'(product_selector_done), 32'd1);
        step(0, 0, 0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        chk("stock_empty_err",  32'(sel_err), 32'd1);
        chk("stock_empty_busy", 32'(busy),    32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 30), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 5),  ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 99) < 10), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 31)),
                 ($urandom_range(0, 99) < 4),  int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
